// File: rtl/trap_sequencer_if.sv
// Signal bundle between the privilege stage / CSR file / fetch stage and the trap sequencer.
// The master side drives requests and the current mstatus; the slave side is the sequencer.
interface trap_sequencer_if;
    logic        MMU_WAIT;
    logic        TRAP_EN;
    logic [31:0] TRAP_PC;
    logic [31:0] TRAP_CODE;
    logic [31:0] TRAP_JMP_TO;
    logic        CHMODE_DO;
    logic [1:0]  CHMODE_TRANS_TO;
    logic [31:0] CHMODE_JMP_TO;
    logic [31:0] CSR_MSTATUS_IN;
    logic        CSR_W_EN;
    logic [11:0] CSR_W_ADDR;
    logic [31:0] CSR_W_DATA;
    logic        FLUSH;
    logic        JMP_DO;
    logic [31:0] JMP_PC;
    logic [1:0]  MODE;
    logic        INT_ALLOW;
    logic        BUSY;

    modport master (
        output MMU_WAIT, TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO,
               CHMODE_DO, CHMODE_TRANS_TO, CHMODE_JMP_TO, CSR_MSTATUS_IN,
        input  CSR_W_EN, CSR_W_ADDR, CSR_W_DATA, FLUSH, JMP_DO, JMP_PC,
               MODE, INT_ALLOW, BUSY
    );

    modport slave (
        input  MMU_WAIT, TRAP_EN, TRAP_PC, TRAP_CODE, TRAP_JMP_TO,
               CHMODE_DO, CHMODE_TRANS_TO, CHMODE_JMP_TO, CSR_MSTATUS_IN,
        output CSR_W_EN, CSR_W_ADDR, CSR_W_DATA, FLUSH, JMP_DO, JMP_PC,
               MODE, INT_ALLOW, BUSY
    );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences the CSR writes, flush and fetch redirect of a trap or xRET, one CSR write per cycle,
// and owns the current privilege mode.
module trap_sequencer #(
    parameter logic [11:0] ADDR_MSTATUS = 12'h300,
    parameter logic [11:0] ADDR_MEPC    = 12'h341,
    parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
    parameter logic [1:0]  RESET_MODE   = 2'b11
) (
    input  logic             CLK,
    input  logic             RST,
    trap_sequencer_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_T_EPC    = 3'd1;
    localparam logic [2:0] S_T_CAUSE  = 3'd2;
    localparam logic [2:0] S_T_STATUS = 3'd3;
    localparam logic [2:0] S_R_STATUS = 3'd4;
    localparam logic [2:0] S_REDIRECT = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] code_q, code_d;
    logic [31:0] target_q, target_d;
    logic [1:0]  trans_q, trans_d;
    logic        is_trap_q, is_trap_d;

    logic        csr_w_en;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        jmp_do;
    logic [31:0] jmp_pc;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pc_d      = pc_q;
        code_d    = code_q;
        target_d  = target_q;
        trans_d   = trans_q;
        is_trap_d = is_trap_q;
        if (!bus.MMU_WAIT) begin
            case (state_q)
                S_IDLE: begin
                    // A trap outranks a simultaneous xRET; the xRET is simply lost.
                    if (bus.TRAP_EN) begin
                        pc_d      = bus.TRAP_PC;
                        code_d    = bus.TRAP_CODE;
                        target_d  = bus.TRAP_JMP_TO;
                        is_trap_d = 1'b1;
                        state_d   = S_T_EPC;
                    end else if (bus.CHMODE_DO) begin
                        target_d  = bus.CHMODE_JMP_TO;
                        trans_d   = bus.CHMODE_TRANS_TO;
                        is_trap_d = 1'b0;
                        state_d   = S_R_STATUS;
                    end
                end
                S_T_EPC:    state_d = S_T_CAUSE;
                S_T_CAUSE:  state_d = S_T_STATUS;
                S_T_STATUS: state_d = S_REDIRECT;
                S_R_STATUS: state_d = S_REDIRECT;
                S_REDIRECT: begin
                    state_d = S_IDLE;
                    mode_d  = is_trap_q ? 2'b11 : trans_q;
                end
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            mode_q    <= RESET_MODE;
            pc_q      <= '0;
            code_q    <= '0;
            target_q  <= '0;
            trans_q   <= '0;
            is_trap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pc_q      <= pc_d;
            code_q    <= code_d;
            target_q  <= target_d;
            trans_q   <= trans_d;
            is_trap_q <= is_trap_d;
        end
    end

    always_comb begin
        csr_w_en   = 1'b0;
        csr_w_addr = '0;
        csr_w_data = '0;
        jmp_do     = 1'b0;
        jmp_pc     = '0;
        case (state_q)
            S_T_EPC: begin
                csr_w_en   = 1'b1;
                csr_w_addr = ADDR_MEPC;
                csr_w_data = pc_q;
            end
            S_T_CAUSE: begin
                csr_w_en   = 1'b1;
                csr_w_addr = ADDR_MCAUSE;
                csr_w_data = code_q;
            end
            S_T_STATUS: begin
                // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- mode being left.
                csr_w_en          = 1'b1;
                csr_w_addr        = ADDR_MSTATUS;
                csr_w_data        = bus.CSR_MSTATUS_IN;
                csr_w_data[7]     = bus.CSR_MSTATUS_IN[3];
                csr_w_data[3]     = 1'b0;
                csr_w_data[12:11] = mode_q;
            end
            S_R_STATUS: begin
                // Return: MIE <- MPIE, MPIE <- 1, MPP <- U.
                csr_w_en          = 1'b1;
                csr_w_addr        = ADDR_MSTATUS;
                csr_w_data        = bus.CSR_MSTATUS_IN;
                csr_w_data[3]     = bus.CSR_MSTATUS_IN[7];
                csr_w_data[7]     = 1'b1;
                csr_w_data[12:11] = 2'b00;
            end
            S_REDIRECT: begin
                jmp_do = 1'b1;
                jmp_pc = target_q;
            end
            default: ;
        endcase
        if (bus.MMU_WAIT) begin
            csr_w_en   = 1'b0;
            csr_w_addr = '0;
            csr_w_data = '0;
            jmp_do     = 1'b0;
            jmp_pc     = '0;
        end
    end

    assign bus.CSR_W_EN   = csr_w_en;
    assign bus.CSR_W_ADDR = csr_w_addr;
    assign bus.CSR_W_DATA = csr_w_data;
    assign bus.JMP_DO     = jmp_do;
    assign bus.JMP_PC     = jmp_pc;
    assign bus.FLUSH      = (state_q != S_IDLE);
    assign bus.BUSY       = (state_q != S_IDLE);
    assign bus.MODE       = mode_q;
    assign bus.INT_ALLOW  = (state_q == S_IDLE) && ((mode_q != 2'b11) || bus.CSR_MSTATUS_IN[3]);
endmodule
